// File: rtl/arbitro_salida.sv
// Egress arbiter: round-robin drain of four class FIFOs into one output FIFO,
// throttled by the output FIFO's almost_full flag, with per-class word counters.
module arbitro_salida #(
  parameter int DATA_SIZE = 12,
  parameter int CNT_SIZE  = 5
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic [DATA_SIZE-1:0] data_in0,
  input  logic [DATA_SIZE-1:0] data_in1,
  input  logic [DATA_SIZE-1:0] data_in2,
  input  logic [DATA_SIZE-1:0] data_in3,
  input  logic                 valid0,
  input  logic                 valid1,
  input  logic                 valid2,
  input  logic                 valid3,
  input  logic                 fifo0_empty,
  input  logic                 fifo1_empty,
  input  logic                 fifo2_empty,
  input  logic                 fifo3_empty,
  input  logic                 out_almost_full,
  output logic                 pop0,
  output logic                 pop1,
  output logic                 pop2,
  output logic                 pop3,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 push,
  output logic [CNT_SIZE-1:0]  cont0,
  output logic [CNT_SIZE-1:0]  cont1,
  output logic [CNT_SIZE-1:0]  cont2,
  output logic [CNT_SIZE-1:0]  cont3,
  output logic [1:0]           state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    STALL  = 2'd2
  } state_t;

  state_t               st;
  logic [1:0]           rr_ptr;
  logic [1:0]           grant_idx;
  logic                 grant_vld;
  logic [1:0]           src_idx;
  logic [1:0]           sel_idx;
  logic                 any_valid;
  logic [3:0]           empty_v;
  logic [3:0]           valid_v;
  logic [3:0]           pop_v;
  logic [DATA_SIZE-1:0] din [4];
  logic [CNT_SIZE-1:0]  cnt [4];

  assign empty_v = {fifo3_empty, fifo2_empty, fifo1_empty, fifo0_empty};
  assign valid_v = {valid3, valid2, valid1, valid0};
  assign din[0]  = data_in0;
  assign din[1]  = data_in1;
  assign din[2]  = data_in2;
  assign din[3]  = data_in3;

  // First non-empty FIFO at or after the round-robin pointer, wrapping mod 4.
  always_comb begin : grant_scan
    // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
    grant_vld = 1'b0;
    grant_idx = rr_ptr;
    for (int i = 0; i < 4; i++) begin
      if (!grant_vld && !empty_v[rr_ptr + 2'(i)]) begin
        grant_vld = 1'b1;
        grant_idx = rr_ptr + 2'(i);
      end
    end
  end

  assign pop_v = (reset_L && st == ACTIVE && !out_almost_full && grant_vld)
               ? (4'b0001 << grant_idx) : 4'b0000;

  // Several valids at once is a protocol error; the lowest index wins.
  always_comb begin : valid_select
    any_valid = |valid_v;
    sel_idx   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (valid_v[i]) sel_idx = 2'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      st       <= IDLE;
      rr_ptr   <= 2'd0;
      src_idx  <= 2'd0;
      push     <= 1'b0;
      data_out <= '0;
      for (int k = 0; k < 4; k++) cnt[k] <= '0;
    end else begin
      case (st)
        IDLE:    if (out_almost_full) st <= STALL;
                 else if (!(&empty_v)) st <= ACTIVE;
        ACTIVE:  if (out_almost_full) st <= STALL;
                 else if (&empty_v) st <= IDLE;
        STALL:   if (!out_almost_full) st <= (&empty_v) ? IDLE : ACTIVE;
        default: st <= IDLE;
      endcase

      if (|pop_v) begin
        rr_ptr  <= grant_idx + 2'd1;
        src_idx <= grant_idx;
      end

      // The word popped last cycle is counted against the class it was granted to.
      push <= any_valid;
      if (any_valid) begin
        data_out     <= din[sel_idx];
        cnt[src_idx] <= cnt[src_idx] + CNT_SIZE'(1);
      end
    end
  end

  assign pop0  = pop_v[0];
  assign pop1  = pop_v[1];
  assign pop2  = pop_v[2];
  assign pop3  = pop_v[3];
  assign cont0 = cnt[0];
  assign cont1 = cnt[1];
  assign cont2 = cnt[2];
  assign cont3 = cnt[3];
  assign state = st;

endmodule

// File: doc/arbitro_salida.md
Name: arbitro_salida

Overview:
- Egress arbiter. Drains the four per-class FIFOs (class 0..3) that the ingress classifier fills, and merges them into a single output FIFO.
- Arbitration is round-robin, one word per cycle, with back-pressure from the output FIFO's almost_full flag.
- Keeps per-class transmitted-word counters for the bench and for the system-level checker.

Parameters:
- DATA_SIZE, 12, word width; bits [11:10] carry the class.
- CNT_SIZE, 5, width of each per-class counter.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset_L  in  1  synchronous active-low reset.
- data_in0..data_in3  in  DATA_SIZE each  read data of class FIFO k; valid one cycle after pop_k.
- valid0..valid3  in  1 each  class FIFO k read data valid; asserted the cycle after an accepted pop_k.
- fifo0_empty..fifo3_empty  in  1 each  class FIFO k empty.
- out_almost_full  in  1  output FIFO almost full.
- pop0..pop3  out  1 each  read strobe to class FIFO k; at most one high per cycle.
- data_out  out  DATA_SIZE  registered word to output FIFO.
- push  out  1  registered write strobe to output FIFO.
- cont0..cont3  out  CNT_SIZE each  words pushed per class.
- state  out  2  FSM state, for debug.

Behaviour:
- Reset (reset_L=0 at posedge):
  - pop0..3=0, push=0, data_out=0, cont0..3=0.
  - rr pointer=0, state=IDLE.
  - Any in-flight word is discarded.
  - pop outputs are gated low combinationally while reset_L=0.
- States:
  - IDLE=0: all class FIFOs empty.
  - ACTIVE=1: popping.
  - STALL=2: output FIFO almost full.
- Transitions, evaluated each posedge when not in reset:
  - IDLE -> ACTIVE if any fifoK_empty=0 and out_almost_full=0.
  - IDLE -> STALL if out_almost_full=1.
  - ACTIVE -> STALL if out_almost_full=1; STALL has priority over IDLE.
  - ACTIVE -> IDLE if all empty and out_almost_full=0.
  - STALL -> ACTIVE when out_almost_full=0 and any non-empty.
  - STALL -> IDLE when out_almost_full=0 and all empty.
- Pop logic (combinational):
  - Only in ACTIVE, and only while out_almost_full=0 in the same cycle.
  - Grant the first non-empty FIFO scanning from pointer upward, modulo 4; assert that pop_k only.
  - Never pop an empty FIFO.
  - If no FIFO is non-empty, no pop.
- Pointer update: on each grant k, pointer <= (k+1) mod 4. The pointer holds otherwise, including through STALL and IDLE.
- Latency:
  - Pop at cycle N.
  - valid_k and data_in_k are sampled at N+1.
  - push=1 and data_out=data_in_k are registered and visible at cycle N+2.
  - Sustained throughput is 1 word/cycle.
- Push pipeline:
  - Each cycle, push <= OR of valid0..3 and data_out <= data of the valid FIFO.
  - If no valid: push <= 0 and data_out holds its last value.
  - More than one valid in the same cycle is a protocol error. Take the lowest index, still push once.
- In-flight words:
  - Up to 2 words may still arrive after out_almost_full rises: one popped the previous cycle, one in the push register.
  - Both are still pushed; no word is ever dropped.
  - Output FIFO almost_full threshold must leave >=2 free slots.
- Counters:
  - cont_k increments by 1 on each push whose source FIFO is k; tracked by the registered grant index, not data bits.
  - Wraps 31 -> 0 (modulo 2^CNT_SIZE), no saturation.
  - At most one counter changes per cycle.
- Class-bit check: if data_in_k[11:10] != k on a valid cycle, the word is still forwarded unchanged. This is a bench assertion, not RTL behaviour.
- Reset mid-operation: pending pops and words are discarded, counters cleared, and the first grant after reset goes to FIFO 0.

Test Plan:
- Reset: hold reset_L=0 for 2 cycles with all FIFOs non-empty -> pop0..3=0, push=0, data_out=0, cont0..3=0, state=0.
- Single class: 3 words 0x001, 0x002, 0x003 in FIFO0 only -> pop0 on 3 consecutive cycles; push with data_out 0x001/0x002/0x003 at N+2..N+4; cont0=3, others 0; state returns to IDLE.
- Round-robin: one word each, 0x0AA/0x4BB/0x8CC/0xCDD in FIFOs 0..3 -> pops in order 0,1,2,3 on 4 consecutive cycles; output order identical; cont0..3=1 each.
- Back-pressure: FIFO2 holds 6 words, out_almost_full rises after the 2nd pop -> at most 2 more pushes, then no pop while STALL. Deassert -> the remaining words are pushed, pointer preserved, total pushed=6, cont2=6.
- Pointer fairness: FIFOs 1 and 3 non-empty, pointer=2 -> grant 3 first, then 1, alternating.
- Wrap: push 33 words through FIFO1 -> cont1=1 (33 mod 32).
- Reset mid-stream: assert reset_L=0 during an active transfer -> counters 0, push=0 next cycle, first grant after release = lowest non-empty FIFO at or after index 0.
